uart_tx: RTL and testbench

UART transmitter: the transmit counterpart of the team's 16x-oversampling UART receiver, sharing its baud tick and frame format. It takes parallel bytes through a valid/ready handshake into a one-entry holding register and serialises them LSB-first as start / data / stop on `tx`. Because the holding register refills while the current frame is still shifting out, frames go back-to-back with no idle gap. It sits between the bridge's FIFO read side and the UART TX pin.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_tx.sv | 94 +++++++++
 tb/tb_uart_tx.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: frame state encoding and bit timing shared by the UART transmitter and receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_e;

    localparam int TICKS_PER_BIT = 16;

endpackage

// File: rtl/uart_tx.sv
// uart_tx: 16x-tick UART transmitter with a one-entry holding register so frames can run back-to-back.
module uart_tx
    import uart_pkg::*;
#(
    parameter int dataBits  = 8,
    parameter int stopTicks = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                inValid,
    output logic                inReady,
    input  logic [dataBits-1:0] dataIn,
    output logic                tx,
    output logic                busy,
    output logic                txDone
);

    localparam int TW = $clog2(stopTicks > TICKS_PER_BIT ? stopTicks : TICKS_PER_BIT);
    localparam int BW = dataBits > 1 ? $clog2(dataBits) : 1;

    uart_state_e         state, state_n;
    logic [dataBits-1:0] hold, shift, shift_n;
    logic                hold_full, load, done_n, tx_n;
    logic [TW-1:0]       tick_cnt, tick_n;
    logic [BW-1:0]       bit_cnt, bit_n;

    assign inReady = ~hold_full;
    assign busy    = (state != IDLE) || hold_full;

    always_comb begin
        state_n = state;
        shift_n = shift;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        load    = 1'b0;
        done_n  = 1'b0;
        if (tick) begin
            case (state)
                IDLE: if (hold_full) begin
                    load    = 1'b1;
                    tick_n  = '0;
                    state_n = START;
                end
                START: if (tick_cnt == TW'(TICKS_PER_BIT - 1)) begin
                    tick_n  = '0;
                    bit_n   = '0;
                    state_n = DATA;
                end else tick_n = tick_cnt + TW'(1);
                DATA: if (tick_cnt == TW'(TICKS_PER_BIT - 1)) begin
                    tick_n  = '0;
                    shift_n = shift >> 1;
                    if (bit_cnt == BW'(dataBits - 1)) state_n = STOP;
                    else bit_n = bit_cnt + BW'(1);
                end else tick_n = tick_cnt + TW'(1);
                STOP: if (tick_cnt == TW'(stopTicks - 1)) begin
                    done_n  = 1'b1;
                    tick_n  = '0;
                    load    = hold_full;
                    state_n = hold_full ? START : IDLE;
                end else tick_n = tick_cnt + TW'(1);
            endcase
        end
        if (load) shift_n = hold;
        // tx is registered, so it is derived from where the FSM is heading
        tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shift     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            tx        <= 1'b1;
            txDone    <= 1'b0;
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            tick_cnt <= tick_n;
            bit_cnt  <= bit_n;
            tx       <= tx_n;
            txDone   <= done_n;
            if (load) hold_full <= 1'b0;
            else if (inValid && !hold_full) begin
                hold_full <= 1'b1;
                hold      <= dataIn;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed and randomized checks of uart_tx against a per-clock frame waveform model.
module tb_uart_tx;

    logic       clk = 1'b0, reset = 1'b0, tick = 1'b0, v1 = 1'b0, v2 = 1'b0, sel = 1'b0;
    logic [7:0] din = 8'h00;
    logic       rdy1, tx1, busy1, done1, rdy2, tx2, busy2, done2;
    logic       mtx, mrdy, mbusy, mdone;
    int         P = 4, tcnt = 0, cyc = 0, ncmp = 0, nerr = 0;
    int         acc_cyc = 0, fall_cyc = 0, fall2 = 0, acc3 = 0, w1 = 0, w2 = 0, w3 = 0;
    int         cnt_a = 0, cnt_b = 0, cnt_c = 0;
    logic [7:0] rb [5];

    uart_tx dut (
        .clk(clk), .reset(reset), .tick(tick), .inValid(v1), .inReady(rdy1),
        .dataIn(din), .tx(tx1), .busy(busy1), .txDone(done1)
    );

    uart_tx #(.stopTicks(32)) dut32 (
        .clk(clk), .reset(reset), .tick(tick), .inValid(v2), .inReady(rdy2),
        .dataIn(din), .tx(tx2), .busy(busy2), .txDone(done2)
    );

    assign mtx   = sel ? tx2 : tx1;
    assign mrdy  = sel ? rdy2 : rdy1;
    assign mbusy = sel ? busy2 : busy1;
    assign mdone = sel ? done2 : done1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(negedge clk);
        tcnt++;
        tick = (tcnt % P) == 0;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b, output int waited);
        int n = 0;
        @(negedge clk);
        din = b;
        if (sel) v2 = 1'b1; else v1 = 1'b1;
        while (!mrdy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("push %02h within bound", b), n < 20000, 1);
        waited = n;
        @(negedge clk);
        acc_cyc = cyc;
        v1 = 1'b0;
        v2 = 1'b0;
    endtask

    // Expected line: start low, dataBits LSB-first, then stop high; each bit 16 ticks of P clocks
    task automatic check_frame(input logic [7:0] b, input int st, input bit b2b);
        int n = 0, bad = 0, dn = 0, len;
        logic e;
        len = (16 * 9 + st) * P;
        while (mtx !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("frame %02h start seen", b), n < 4000, 1);
        fall_cyc = cyc;
        for (int k = 0; k < len; k++) begin
            int bi = k / (16 * P);
            e = bi == 0 ? 1'b0 : bi <= 8 ? b[bi-1] : 1'b1;
            if (mtx !== e || mbusy !== 1'b1) bad++;
            if (k > 0 && mdone !== 1'b0) dn++;
            @(negedge clk);
        end
        chk($sformatf("frame %02h bad line/busy samples", b), bad, 0);
        chk($sformatf("frame %02h early txDone", b), dn, 0);
        chk($sformatf("frame %02h txDone at stop end", b), mdone, 1);
        chk($sformatf("frame %02h line after stop", b), mtx, b2b ? 0 : 1);
    endtask

    initial begin
        // reset held with a byte offered
        v1 = 1'b1; v2 = 1'b1; din = 8'hAB;
        repeat (10) @(negedge clk);
        chk("reset tx", tx1, 1);
        chk("reset inReady", rdy1, 1);
        chk("reset busy", busy1, 0);
        chk("reset txDone", done1, 0);
        chk("reset busy dut32", busy2, 0);
        v1 = 1'b0; v2 = 1'b0; reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("post-reset nothing accepted", busy1, 0);
        chk("post-reset line idle", tx1, 1);

        // 0x55 with tick every 4 clocks
        P = 4;
        push(8'h55, w1);
        check_frame(8'h55, 16, 0);
        chk("0x55 latency min", (fall_cyc - acc_cyc) >= 1, 1);
        chk("0x55 latency max", (fall_cyc - acc_cyc) <= P + 1, 1);
        @(negedge clk);
        chk("0x55 txDone one clk", done1, 0);

        // back-to-back 0xA3 then 0x0F
        fork
            begin push(8'hA3, w1); push(8'h0F, w2); end
            begin check_frame(8'hA3, 16, 1); check_frame(8'h0F, 16, 0); end
        join
        @(negedge clk);
        chk("b2b txDone one clk", done1, 0);

        // backpressure: three bytes offered continuously
        P = $urandom_range(2, 5);
        for (int i = 0; i < 3; i++) rb[i] = 8'($urandom);
        fork
            begin
                push(rb[0], w1); push(rb[1], w2); push(rb[2], w3);
                acc3 = acc_cyc;
            end
            begin
                check_frame(rb[0], 16, 1);
                check_frame(rb[1], 16, 1);
                fall2 = fall_cyc;
                check_frame(rb[2], 16, 0);
            end
        join
        chk("third byte saw inReady low", w3 > 0, 1);
        chk("third byte accepted clk after load", acc3 - fall2, 1);
        cnt_a = 0;
        repeat (40 * P) begin
            @(negedge clk);
            if (busy1 !== 1'b0 || tx1 !== 1'b1 || done1 !== 1'b0) cnt_a++;
        end
        chk("no duplicate after backpressure", cnt_a, 0);

        // reset during data bit 3 of 0xFF with a second byte pending
        P = 4;
        fork
            begin push(8'hFF, w1); push(8'h77, w2); end
            begin
                cnt_b = 0;
                while (tx1 !== 1'b0 && cnt_b < 4000) begin @(negedge clk); cnt_b++; end
                fall_cyc = cyc;
            end
        join
        chk("0xFF start seen", cnt_b < 4000, 1);
        while (cyc < fall_cyc + 4 * 16 * P + 8 * P) @(negedge clk);
        chk("0xFF mid-frame busy", busy1, 1);
        #1 reset = 1'b0;
        #1;
        chk("async reset tx", tx1, 1);
        chk("async reset busy", busy1, 0);
        chk("async reset inReady", rdy1, 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        cnt_c = 0;
        repeat (700) begin
            @(negedge clk);
            if (done1 !== 1'b0 || tx1 !== 1'b1 || busy1 !== 1'b0) cnt_c++;
        end
        chk("pending byte discarded, no txDone", cnt_c, 0);
        push(8'h12, w1);
        check_frame(8'h12, 16, 0);
        chk("0x12 latency max", (fall_cyc - acc_cyc) <= P + 1, 1);

        // randomized back-to-back stream
        P = $urandom_range(2, 5);
        for (int i = 0; i < 5; i++) rb[i] = 8'($urandom);
        fork
            begin for (int i = 0; i < 5; i++) push(rb[i], w1); end
            begin for (int j = 0; j < 5; j++) check_frame(rb[j], 16, j < 4); end
        join
        @(negedge clk);
        chk("random stream txDone one clk", done1, 0);

        // two stop bits
        P = 4;
        sel = 1'b1;
        push(8'h00, w1);
        check_frame(8'h00, 32, 0);
        @(negedge clk);
        chk("stop32 txDone one clk", done2, 0);
        chk("stop32 idle", busy2, 0);
        chk("default dut untouched", busy1, 0);
        sel = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
